// File: rtl/cache_request_responder.sv
// -----------------------------------------------------------------------------
// cache_request_responder
//
// Storage-side endpoint for the 104-bit flattened cache request. One request
// is accepted per valid/ready handshake. WRITE and DRAM_FILL requests update a
// set-associative tag/data array. A READ is answered with a burst of
// CACHE_SETS beats, one per set in ascending set order, so that the requester
// can do its own physical-tag compare across all ways.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   reqValid       flatRequest valid this cycle
//   reqReady       responder can accept a request (IDLE only)
//   flatRequest    packed request:
//                  [103:98] index, [97:94] blockOffset, [93:72] tag,
//                  [71:40] writeData, [39:8] requestType, [7] isValid,
//                  [6:3] writeEnable, [2:0] writeSet
//   respValid      read beat valid
//   respReady      requester accepts the beat
//   respSet        set number carried by this beat
//   respTag        stored tag, or TAG_POISON for an invalid line
//   respLineValid  line valid bit
//   respData       stored word, or WORD_POISON for an invalid line
//   respLast       high on the beat for the last set
//   wrAck          one-cycle pulse per committed write/fill
//   badType        one-cycle pulse per unknown requestType
// -----------------------------------------------------------------------------
module cache_request_responder #(
    parameter int          CACHE_SETS  = 8,
    parameter logic [31:0] WORD_POISON = 32'hBADF00D,
    parameter logic [21:0] TAG_POISON  = 22'h277BAD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          reqValid,
    output logic                          reqReady,
    input  logic [103:0]                  flatRequest,
    output logic                          respValid,
    input  logic                          respReady,
    output logic [$clog2(CACHE_SETS)-1:0] respSet,
    output logic [21:0]                   respTag,
    output logic                          respLineValid,
    output logic [31:0]                   respData,
    output logic                          respLast,
    output logic                          wrAck,
    output logic                          badType
);

    localparam int            SW       = $clog2(CACHE_SETS);
    localparam logic [SW-1:0] LAST_SET = SW'(CACHE_SETS - 1);
    localparam logic [SW-1:0] SET_ONE  = SW'(1);
    localparam logic [SW-1:0] SET_ZERO = SW'(0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    // Merge the enabled bytes of new_word into old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Request fields
    logic [5:0]  w_idx;
    logic [1:0]  w_word;
    logic        w_unused_off;
    logic [21:0] w_tag;
    logic [31:0] w_wdata;
    logic [31:0] w_rtype;
    logic        w_isvalid;
    logic [3:0]  w_we;
    logic [2:0]  w_wr_set;

    assign w_idx        = flatRequest[103:98];
    assign w_word       = flatRequest[97:96];
    // Byte-within-word bits are irrelevant for word-granular storage.
    assign w_unused_off = ^flatRequest[95:94];
    assign w_tag        = flatRequest[93:72];
    assign w_wdata      = flatRequest[71:40];
    assign w_rtype      = flatRequest[39:8];
    assign w_isvalid    = flatRequest[7];
    assign w_we         = flatRequest[6:3];
    assign w_wr_set     = flatRequest[2:0];

    // Storage
    logic [31:0] r_data [CACHE_SETS][64][4];
    logic [21:0] r_tag  [CACHE_SETS][64];
    logic [63:0] r_vld  [CACHE_SETS];

    // Control
    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_idx;
    logic [1:0]  r_word;
    logic        w_hs;
    logic        w_do_read;
    logic        w_do_write;
    logic        w_is_fill;
    logic        w_is_bad;
    logic        w_beat_acc;

    // Beat lookup
    logic [SW-1:0] w_rd_set;
    logic [5:0]    w_rd_idx;
    logic [1:0]    w_rd_word;
    logic          w_rd_hit;
    logic [21:0]   w_rd_tag;
    logic [31:0]   w_rd_data;

    // Request decode and next-state logic.
    always_comb begin
        w_hs         = reqValid && reqReady;
        w_do_read    = 1'b0;
        w_do_write   = 1'b0;
        w_is_fill    = (w_rtype == 32'd2);
        w_is_bad     = 1'b0;
        w_beat_acc   = 1'b0;
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hs && w_isvalid) begin
                    w_do_read  = (w_rtype == 32'd0);
                    // Out-of-range sets are silently ignored (no update, no ack).
                    w_do_write = ((w_rtype == 32'd1) || (w_rtype == 32'd2)) &&
                                 ({29'd0, w_wr_set} < 32'(CACHE_SETS));
                    w_is_bad   = (w_rtype > 32'd2);
                end else begin
                    w_do_read  = 1'b0;
                    w_do_write = 1'b0;
                    w_is_bad   = 1'b0;
                end
                if (w_do_read) begin
                    w_state_next = ST_READ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                w_beat_acc = respValid && respReady;
                if (w_beat_acc && respLast) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_READ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Select which set/line feeds the next beat: set 0 of the incoming
    // request on entry, otherwise the following set of the captured line.
    always_comb begin
        w_rd_set  = SET_ZERO;
        w_rd_idx  = w_idx;
        w_rd_word = w_word;
        if (r_state == ST_IDLE) begin
            w_rd_set  = SET_ZERO;
            w_rd_idx  = w_idx;
            w_rd_word = w_word;
        end else begin
            w_rd_set  = respSet + SET_ONE;
            w_rd_idx  = r_idx;
            w_rd_word = r_word;
        end
        w_rd_hit  = r_vld[w_rd_set][w_rd_idx];
        w_rd_tag  = w_rd_hit ? r_tag[w_rd_set][w_rd_idx] : TAG_POISON;
        w_rd_data = w_rd_hit ? r_data[w_rd_set][w_rd_idx][w_rd_word] : WORD_POISON;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Response registers, handshake ready and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqReady      <= 1'b0;
            respValid     <= 1'b0;
            respSet       <= SET_ZERO;
            respTag       <= 22'd0;
            respLineValid <= 1'b0;
            respData      <= 32'd0;
            respLast      <= 1'b0;
            wrAck         <= 1'b0;
            badType       <= 1'b0;
            r_idx         <= 6'd0;
            r_word        <= 2'd0;
        end else begin
            reqReady <= (w_state_next == ST_IDLE);
            wrAck    <= w_do_write;
            badType  <= w_is_bad;
            if (w_do_read) begin
                r_idx         <= w_idx;
                r_word        <= w_word;
                respValid     <= 1'b1;
                respSet       <= w_rd_set;
                respTag       <= w_rd_tag;
                respLineValid <= w_rd_hit;
                respData      <= w_rd_data;
                respLast      <= (w_rd_set == LAST_SET);
            end else if (w_beat_acc) begin
                if (respLast) begin
                    respValid <= 1'b0;
                    respLast  <= 1'b0;
                end else begin
                    respSet       <= w_rd_set;
                    respTag       <= w_rd_tag;
                    respLineValid <= w_rd_hit;
                    respData      <= w_rd_data;
                    respLast      <= (w_rd_set == LAST_SET);
                end
            end
        end
    end

    // Line valid bits: cleared by reset, set by every committed write/fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < CACHE_SETS; s++) begin
                r_vld[s] <= 64'd0;
            end
        end else if (w_do_write) begin
            r_vld[w_wr_set][w_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; contents are qualified by r_vld.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            if (w_is_fill) begin
                r_data[w_wr_set][w_idx][w_word] <= w_wdata;
            end else begin
                r_data[w_wr_set][w_idx][w_word] <=
                    merge_bytes(r_data[w_wr_set][w_idx][w_word], w_wdata, w_we);
            end
            r_tag[w_wr_set][w_idx] <= w_tag;
        end
    end

endmodule

// File: tb/tb_cache_request_responder.sv
module tb_cache_request_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         reqValid;
    logic         reqReady;
    logic [103:0] flatRequest;
    logic         respValid;
    logic         respReady;
    logic [2:0]   respSet;
    logic [21:0]  respTag;
    logic         respLineValid;
    logic [31:0]  respData;
    logic         respLast;
    logic         wrAck;
    logic         badType;

    int checks = 0;
    int errors = 0;

    // Reference storage: plain arrays indexed [set][index][word].
    logic [31:0] m_data [8][64][4];
    logic [21:0] m_tag  [8][64];
    bit          m_vld  [8][64];

    // Pending write presented while a burst is in flight.
    logic [5:0]  pw_idx;
    logic [3:0]  pw_off;
    logic [21:0] pw_tag;
    logic [31:0] pw_wd;
    logic [3:0]  pw_we;
    logic [2:0]  pw_set;

    logic [59:0] got;
    assign got = {respValid, respSet, respTag, respLineValid, respData, respLast};

    cache_request_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reqValid      (reqValid),
        .reqReady      (reqReady),
        .flatRequest   (flatRequest),
        .respValid     (respValid),
        .respReady     (respReady),
        .respSet       (respSet),
        .respTag       (respTag),
        .respLineValid (respLineValid),
        .respData      (respData),
        .respLast      (respLast),
        .wrAck         (wrAck),
        .badType       (badType)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int s = 0; s < 8; s++)
            for (int i = 0; i < 64; i++)
                m_vld[s][i] = 1'b0;
    endfunction

    function automatic void model_apply(input logic [5:0] idx, input logic [3:0] off,
                                        input logic [21:0] tg, input logic [31:0] wd,
                                        input logic [31:0] rt, input bit iv,
                                        input logic [3:0] we, input logic [2:0] ws);
        int w;
        w = int'(off[3:2]);
        if (!iv || rt == 32'd0 || rt > 32'd2) return;
        if (rt == 32'd2) begin
            m_data[ws][idx][w] = wd;
        end else begin
            for (int b = 0; b < 4; b++)
                if (we[b]) m_data[ws][idx][w][8*b +: 8] = wd[8*b +: 8];
        end
        m_tag[ws][idx] = tg;
        m_vld[ws][idx] = 1'b1;
    endfunction

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send_req(input logic [5:0] idx, input logic [3:0] off,
                            input logic [21:0] tg, input logic [31:0] wd,
                            input logic [31:0] rt, input bit iv,
                            input logic [3:0] we, input logic [2:0] ws);
        int n;
        flatRequest = {idx, off, tg, wd, rt, iv, we, ws};
        reqValid = 1'b1;
        n = 0;
        while (reqReady !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL req_accept_timeout reqReady=%b expected=1", reqReady);
            reqValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        model_apply(idx, off, tg, wd, rt, iv, we, ws);
        @(negedge clk);
    endtask

    // Issue a READ and check every beat against the reference storage.
    task automatic test_read_burst(input logic [5:0] idx, input logic [3:0] off,
                                   input int stall_beat, input int stall_len,
                                   input bit pend);
        logic [59:0] exp;
        bit v;
        int w;
        w = int'(off[3:2]);
        send_req(idx, off, 22'd0, 32'd0, 32'd0, 1'b1, 4'd0, 3'd0);
        if (pend) begin
            flatRequest = {pw_idx, pw_off, pw_tag, pw_wd, 32'd1, 1'b1, pw_we, pw_set};
            reqValid = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            v = m_vld[k][idx];
            exp = {1'b1, 3'(k), v ? m_tag[k][idx] : 22'h277BAD, v,
                   v ? m_data[k][idx][w] : 32'h0BADF00D, (k == 7)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL read_beat idx=%0d set=%0d got=%h expected=%h", idx, k, got, exp);
            end
            checks++;
            if (reqReady !== 1'b0 || wrAck !== 1'b0) begin
                errors++;
                $display("FAIL busy_during_burst set=%0d reqReady=%b wrAck=%b expected=0,0", k, reqReady, wrAck);
            end
            if (k == stall_beat) begin
                respReady = 1'b0;
                for (int c = 0; c < stall_len; c++) begin
                    @(negedge clk);
                    checks++;
                    if (got !== exp || reqReady !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold set=%0d cyc=%0d got=%h/%b expected=%h/0", k, c, got, reqReady, exp);
                    end
                end
                respReady = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (respValid !== 1'b0 || reqReady !== 1'b1) begin
            errors++;
            $display("FAIL burst_end respValid=%b reqReady=%b expected=0,1", respValid, reqReady);
        end
        if (pend) begin
            @(negedge clk);
            checks++;
            if (wrAck !== 1'b1) begin
                errors++;
                $display("FAIL pending_write_ack wrAck=%b expected=1", wrAck);
            end
            reqValid = 1'b0;
            model_apply(pw_idx, pw_off, pw_tag, pw_wd, 32'd1, 1'b1, pw_we, pw_set);
            @(negedge clk);
            checks++;
            if (wrAck !== 1'b0) begin
                errors++;
                $display("FAIL pending_ack_width wrAck=%b expected=0", wrAck);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        reqValid = 1'b0;
        respReady = 1'b1;
        flatRequest = 104'd0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({reqReady, got, wrAck, badType} !== 63'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected=0", {reqReady, got, wrAck, badType});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset reqReady=%b expected=1", reqReady);
        end
    endtask

    task automatic test_fill();
        send_req(6'd5, 4'd4, 22'h00ABC, 32'h11223344, 32'd2, 1'b1, 4'd0, 3'd3);
        checks++;
        if (wrAck !== 1'b1 || badType !== 1'b0) begin
            errors++;
            $display("FAIL fill_ack wrAck=%b badType=%b expected=1,0", wrAck, badType);
        end
        @(negedge clk);
        checks++;
        if (wrAck !== 1'b0) begin
            errors++;
            $display("FAIL fill_ack_width wrAck=%b expected=0", wrAck);
        end
        test_read_burst(6'd5, 4'd4, -1, 0, 1'b0);
    endtask

    task automatic test_write();
        send_req(6'd5, 4'd4, 22'h00ABC, 32'hAABBCCDD, 32'd1, 1'b1, 4'b0101, 3'd3);
        checks++;
        if (wrAck !== 1'b1) begin
            errors++;
            $display("FAIL write_ack wrAck=%b expected=1", wrAck);
        end
        @(negedge clk);
        test_read_burst(6'd5, 4'd4, -1, 0, 1'b0);
    endtask

    task automatic test_stall_pending();
        pw_idx = 6'd7; pw_off = 4'd0; pw_tag = 22'h00003;
        pw_wd = 32'h55AA55AA; pw_we = 4'b1000; pw_set = 3'd0;
        test_read_burst(6'd5, 4'd4, 2, 5, 1'b1);
        test_read_burst(6'd7, 4'd0, -1, 0, 1'b0);
    endtask

    task automatic test_bad_type();
        send_req(6'd5, 4'd4, 22'h3FFFF, 32'hFFFFFFFF, 32'd7, 1'b1, 4'hF, 3'd3);
        checks++;
        if (badType !== 1'b1 || wrAck !== 1'b0) begin
            errors++;
            $display("FAIL bad_type_pulse badType=%b wrAck=%b expected=1,0", badType, wrAck);
        end
        @(negedge clk);
        checks++;
        if (badType !== 1'b0) begin
            errors++;
            $display("FAIL bad_type_width badType=%b expected=0", badType);
        end
        send_req(6'd5, 4'd4, 22'h3FFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 4'hF, 3'd3);
        checks++;
        if (wrAck !== 1'b0 || badType !== 1'b0 || reqReady !== 1'b1) begin
            errors++;
            $display("FAIL invalid_dropped wrAck=%b badType=%b reqReady=%b expected=0,0,1", wrAck, badType, reqReady);
        end
        test_read_burst(6'd5, 4'd4, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        flatRequest = {6'd2, 4'd8, 22'h00001, 32'hCAFEBABE, 32'd2, 1'b1, 4'd0, 3'd1};
        reqValid = 1'b1;
        @(negedge clk);
        checks++;
        if (wrAck !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ack wrAck=%b expected=1", wrAck);
        end
        model_apply(6'd2, 4'd8, 22'h00001, 32'hCAFEBABE, 32'd2, 1'b1, 4'd0, 3'd1);
        flatRequest = {6'd2, 4'd8, 22'h00002, 32'h12345678, 32'd1, 1'b1, 4'b1111, 3'd6};
        @(negedge clk);
        checks++;
        if (wrAck !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_ack wrAck=%b expected=1", wrAck);
        end
        reqValid = 1'b0;
        model_apply(6'd2, 4'd8, 22'h00002, 32'h12345678, 32'd1, 1'b1, 4'b1111, 3'd6);
        @(negedge clk);
        checks++;
        if (wrAck !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack_end wrAck=%b expected=0", wrAck);
        end
        test_read_burst(6'd2, 4'd8, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        int op;
        logic [5:0]  idx;
        logic [3:0]  off;
        logic [21:0] tg;
        logic [31:0] wd;
        logic [31:0] rt;
        logic [3:0]  we;
        logic [2:0]  ws;
        bit          iv;
        bit          exp_ack;
        bit          exp_bad;
        for (int it = 0; it < 40; it++) begin
            op  = int'($urandom_range(0, 9));
            idx = ($urandom_range(0, 1) == 1) ? 6'd5 : 6'($urandom_range(0, 3));
            off = 4'($urandom);
            tg  = 22'($urandom);
            wd  = $urandom;
            we  = 4'($urandom);
            ws  = 3'($urandom);
            if (op <= 2) begin
                test_read_burst(idx, off, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                                int'($urandom_range(1, 3)), 1'b0);
            end else begin
                iv = 1'b1;
                if (op <= 5) rt = 32'd1;
                else if (op <= 7) rt = 32'd2;
                else if (op == 8) begin
                    rt = $urandom;
                    if (rt < 32'd3) rt = 32'd3;
                end else begin
                    rt = 32'($urandom_range(0, 2));
                    iv = 1'b0;
                end
                exp_ack = iv && (rt == 32'd1 || rt == 32'd2);
                exp_bad = iv && (rt > 32'd2);
                send_req(idx, off, tg, wd, rt, iv, we, ws);
                checks++;
                if (wrAck !== exp_ack || badType !== exp_bad || reqReady !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_pulse it=%0d rt=%0d iv=%b got=%b%b%b expected=%b%b1",
                             it, rt, iv, wrAck, badType, reqReady, exp_ack, exp_bad);
                end
                @(negedge clk);
                checks++;
                if (wrAck !== 1'b0 || badType !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_pulse_width it=%0d got=%b%b expected=00", it, wrAck, badType);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        send_req(6'd5, 4'd4, 22'd0, 32'd0, 32'd0, 1'b1, 4'd0, 3'd0);
        repeat (4) @(negedge clk);
        checks++;
        if (respValid !== 1'b1 || respSet !== 3'd4) begin
            errors++;
            $display("FAIL mid_burst_position respValid=%b respSet=%0d expected=1,4", respValid, respSet);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (respValid !== 1'b0 || reqReady !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_drop respValid=%b reqReady=%b expected=0,0", respValid, reqReady);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        test_read_burst(6'd5, 4'd4, -1, 0, 1'b0);
        test_read_burst(6'd2, 4'd8, -1, 0, 1'b0);
        test_read_burst(6'd7, 4'd0, -1, 0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_burst(6'd5, 4'd4, -1, 0, 1'b0);
        test_fill();
        test_write();
        test_stall_pending();
        test_bad_type();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
